// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the MEM stage: MEM/WB buffer field offsets,
// the MEM stage state enum, the bubble constant and a helper that packs
// one MEM/WB buffer entry.
//   WB_RW   [134]     register write enable
//   WB_M2R  [133]     write-back selects loaded data
//   WB_RES  [132:69]  ALU result
//   WB_LOAD [68:5]    loaded data
//   WB_REG  [4:0]     destination register
package cpu_pkg;

    localparam int WB_W        = 135;
    localparam int WB_REG_LSB  = 0;
    localparam int WB_LOAD_LSB = 5;
    localparam int WB_RES_LSB  = 69;
    localparam int WB_M2R      = 133;
    localparam int WB_RW       = 134;

    localparam logic [WB_W-1:0] WB_BUBBLE = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    // Builds one MEM/WB entry in the field order the write-back stage expects.
    function automatic logic [WB_W-1:0] pack_wb(
        input logic        reg_write,
        input logic        mem_to_reg,
        input logic [63:0] result,
        input logic [63:0] loaded,
        input logic [4:0]  rd
    );
        logic [WB_W-1:0] entry;
        entry                               = '0;
        entry[WB_RW]                        = reg_write;
        entry[WB_M2R]                       = mem_to_reg;
        entry[WB_RES_LSB +: 64]             = result;
        entry[WB_LOAD_LSB +: 64]            = loaded;
        entry[WB_REG_LSB +: 5]              = rd;
        return entry;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
// Data-memory port of the MEM stage using a req/gnt/rvalid handshake.
//   req    stage -> memory   request pending (held until gnt)
//   we     stage -> memory   1 = store
//   addr   stage -> memory   byte address
//   wdata  stage -> memory   store data
//   gnt    memory -> stage   request accepted this cycle
//   rvalid memory -> stage   load data valid this cycle
//   rdata  memory -> stage   load data
// Modports: master (MEM stage side), slave (memory side).
interface mem_access_stage_if #(
    parameter int DATA_W = 64
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM pipeline stage. Accepts one instruction from EX, performs a load or
// store over the data-memory interface and registers the 135-bit MEM/WB
// buffer. EX is stalled (ex_ready low) while a memory access is in flight.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ex_valid / ex_ready     EX handshake (ex_ready high only in IDLE)
//   ex_alu_result           ALU result, also the memory address
//   ex_store_data, ex_rd    store data, destination register
//   ex_mem_read/_write      load / store (both set = store)
//   ex_mem_to_reg/_reg_write  write-back control
//   dmem                    data-memory master port
//   wb_buf                  MEM/WB buffer, bubble on any non-retiring edge
//   dmem_timeout            one-cycle pulse when an access is aborted
//   align_fault             one-cycle pulse on a misaligned memory op
// Optional feature: define MEM_ALIGN_CHECK_EN to reject memory ops whose
// address is not 8-byte aligned; otherwise align_fault stays 0.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [DATA_W-1:0]    ex_alu_result,
    input  logic [DATA_W-1:0]    ex_store_data,
    input  logic [REG_W-1:0]     ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic                 ex_mem_to_reg,
    input  logic                 ex_reg_write,
    mem_access_stage_if.master   dmem,
    output logic [WB_W-1:0]      wb_buf,
    output logic                 dmem_timeout,
    output logic                 align_fault
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) + 1 : 1;

    mem_state_t         state, state_next;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;

    logic               lat_rd_valid_unused;
    logic [REG_W-1:0]   lat_rd, lat_rd_next;
    logic               lat_rw, lat_rw_next;
    logic               lat_m2r, lat_m2r_next;

    logic               req_next, we_next, timeout_next, align_next;
    logic [DATA_W-1:0]  addr_next, wdata_next;
    logic [WB_W-1:0]    wb_next;

    logic               accept, is_mem, misaligned, timeout_hit;

    assign lat_rd_valid_unused = 1'b0;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid & ex_ready;
    assign is_mem   = ex_mem_read | ex_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = is_mem & (|ex_alu_result[2:0]);
`else
    assign misaligned = 1'b0;
`endif

    // The counter holds the number of edges already spent in REQ/WAIT, so the
    // edge that would bring it to MAX_WAIT is the one that aborts.
    assign timeout_hit = (MAX_WAIT != 0) && (state != IDLE) &&
                         (wait_cnt == CNT_W'(MAX_WAIT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; timeout takes priority over gnt/rvalid on the same edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mem && !misaligned) state_next = REQ;
            REQ: begin
                if (timeout_hit)   state_next = IDLE;
                else if (dmem.gnt) state_next = dmem.we ? IDLE : WAIT;
            end
            WAIT: begin
                if (timeout_hit || dmem.rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values for every registered output and latched instruction field.
    // dmem.addr doubles as the latched ALU result for memory ops.
    always_comb begin
        wb_next       = WB_BUBBLE;
        req_next      = dmem.req;
        we_next       = dmem.we;
        addr_next     = dmem.addr;
        wdata_next    = dmem.wdata;
        timeout_next  = 1'b0;
        align_next    = 1'b0;
        wait_cnt_next = (state == IDLE) ? '0 : wait_cnt + 1'b1;
        lat_rd_next   = lat_rd;
        lat_rw_next   = lat_rw;
        lat_m2r_next  = lat_m2r;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_next = pack_wb(ex_reg_write, ex_mem_to_reg,
                                          ex_alu_result, '0, ex_rd);
                    end else if (misaligned) begin
                        align_next = 1'b1;
                    end else begin
                        req_next     = 1'b1;
                        we_next      = ex_mem_write;
                        addr_next    = ex_alu_result;
                        wdata_next   = ex_store_data;
                        lat_rd_next  = ex_rd;
                        lat_rw_next  = ex_reg_write;
                        lat_m2r_next = ex_mem_to_reg;
                    end
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    req_next     = 1'b0;
                    timeout_next = 1'b1;
                end else if (dmem.gnt) begin
                    req_next = 1'b0;
                    if (dmem.we)
                        wb_next = pack_wb(lat_rw, lat_m2r, dmem.addr, '0, lat_rd);
                end
            end
            WAIT: begin
                if (timeout_hit)
                    timeout_next = 1'b1;
                else if (dmem.rvalid)
                    wb_next = pack_wb(lat_rw, lat_m2r, dmem.addr, dmem.rdata, lat_rd);
            end
            default: ;
        endcase
    end

    // Registered outputs and latched fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_buf       <= WB_BUBBLE;
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.addr    <= '0;
            dmem.wdata   <= '0;
            dmem_timeout <= 1'b0;
            align_fault  <= 1'b0;
            wait_cnt     <= '0;
            lat_rd       <= '0;
            lat_rw       <= 1'b0;
            lat_m2r      <= 1'b0;
        end else begin
            wb_buf       <= wb_next;
            dmem.req     <= req_next;
            dmem.we      <= we_next;
            dmem.addr    <= addr_next;
            dmem.wdata   <= wdata_next;
            dmem_timeout <= timeout_next;
            align_fault  <= align_next | lat_rd_valid_unused;
            wait_cnt     <= wait_cnt_next;
            lat_rd       <= lat_rd_next;
            lat_rw       <= lat_rw_next;
            lat_m2r      <= lat_m2r_next;
        end
    end

endmodule
